// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide-unit controller: sequences the shared signed 32x32
// multiplier for MULT/MULTU, corrects unsigned products, handles MTHI/MTLO.
module mdu_ctrl #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  output logic        mul_en,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  localparam logic [3:0] LAST = 4'(LATENCY - 1);

  state_t      state, state_n;
  logic [3:0]  cnt;
  logic        op_u;
  logic        acc_mul, acc_mt, wb_fire;
  logic [63:0] prod;

  // The multiplier is signed; an operand with bit 31 set was read as x-2^32,
  // so add the other operand back in at weight 2^32 (mod 2^64).
  always_comb begin
    prod = mul_z;
    if (op_u) begin
      if (mul_a[31]) prod = prod + {mul_b, 32'b0};
      if (mul_b[31]) prod = prod + {mul_a, 32'b0};
    end
  end

  always_comb begin
    state_n = state;
    acc_mul = 1'b0;
    acc_mt  = 1'b0;
    wb_fire = 1'b0;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          if (!op[1]) begin
            acc_mul = 1'b1;
            state_n = RUN;
          end else if (!done) begin
            // a move right behind another done pulse waits a cycle so done
            // never stays high two cycles running
            acc_mt = 1'b1;
          end
        end
      end
      RUN: begin
        if (cancel)           state_n = IDLE;
        else if (cnt == LAST) state_n = WB;
      end
      WB: begin
        state_n = IDLE;
        wb_fire = !cancel;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      op_u   <= 1'b0;
      mul_a  <= '0;
      mul_b  <= '0;
      mul_en <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy   <= (state_n != IDLE);
      mul_en <= (state_n != IDLE);
      done   <= wb_fire | acc_mt;
      if (acc_mul) begin
        mul_a <= rs_val;
        mul_b <= rt_val;
        op_u  <= op[0];
        cnt   <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + 4'd1;
      end
      if (wb_fire) begin
        {hi, lo} <= prod;
      end else if (acc_mt) begin
        if (op[0]) lo <= rs_val;
        else       hi <= rs_val;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed + random bench for mdu_ctrl with a behavioural signed multiplier
// and an arithmetic HI/LO reference model.
module tb_mdu_ctrl;
  localparam int L = 2;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, cancel = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        mul_en, busy, done;
  logic [31:0] mul_a, mul_b, hi, lo;
  logic [63:0] mul_z = '0;

  int checks = 0, errors = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  always #5 clk = ~clk;

  mdu_ctrl #(.LATENCY(L)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .cancel(cancel), .mul_en(mul_en), .mul_a(mul_a),
    .mul_b(mul_b), .mul_z(mul_z), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  // shared signed multiplier: samples on falling edge, clears when disabled
  always @(negedge clk) begin
    if (mul_en) mul_z <= 64'(longint'($signed(mul_a)) * longint'($signed(mul_b)));
    else        mul_z <= 64'd0;
  end

  function automatic logic [63:0] ref_prod(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (o == 2'b00) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return 64'(ua * ub);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int cancel_at, input int inject_at);
    logic [63:0] p;
    int nb;
    p  = ref_prod(o, a, b);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    step();
    start = 1'b0;
    nb = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      nb++;
      chk("done_low_while_busy", 64'(done), 64'd0);
      chk("mul_en_while_busy", 64'(mul_en), 64'd1);
      chk("mul_a_held", 64'(mul_a), 64'(a));
      chk("mul_b_held", 64'(mul_b), 64'(b));
      if (i == cancel_at) cancel = 1'b1;
      if (i == inject_at) begin
        start = 1'b1; op = 2'b00; rs_val = $urandom; rt_val = $urandom;
      end else begin
        start = 1'b0;
      end
      step();
      cancel = 1'b0;
    end
    start = 1'b0;
    if (cancel_at >= 0) begin
      chk("cancel_busy_cycles", 64'(nb), 64'(cancel_at + 1));
      chk("cancel_no_done", 64'(done), 64'd0);
      chk("cancel_mul_en", 64'(mul_en), 64'd0);
    end else begin
      chk("busy_cycles", 64'(nb), 64'(L + 1));
      chk("done_pulse", 64'(done), 64'd1);
      chk("mul_en_off", 64'(mul_en), 64'd0);
      {exp_hi, exp_lo} = p;
    end
    chk("hi", 64'(hi), 64'(exp_hi));
    chk("lo", 64'(lo), 64'(exp_lo));
    chk("mul_a_retained", 64'(mul_a), 64'(a));
    step();
    chk("done_single", 64'(done), 64'd0);
    chk("hi_stable", 64'(hi), 64'(exp_hi));
    chk("lo_stable", 64'(lo), 64'(exp_lo));
  endtask

  task automatic run_mt(input logic [1:0] o, input logic [31:0] a);
    op = o; rs_val = a; start = 1'b1;
    step();
    start = 1'b0;
    if (o[0]) exp_lo = a;
    else      exp_hi = a;
    chk("mt_busy", 64'(busy), 64'd0);
    chk("mt_done", 64'(done), 64'd1);
    chk("mt_hi", 64'(hi), 64'(exp_hi));
    chk("mt_lo", 64'(lo), 64'(exp_lo));
    step();
    chk("mt_done_single", 64'(done), 64'd0);
    chk("mt_busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    // reset state
    #2;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mul_en", 64'(mul_en), 64'd0);
    chk("rst_mul_ab", {mul_a, mul_b}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // signed: -3 * 5
    run_mul(2'b00, 32'hFFFFFFFD, 32'h00000005, -1, -1);
    chk("mult_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);

    // unsigned corrections
    run_mul(2'b01, 32'hFFFFFFFF, 32'h00000002, -1, -1);
    chk("multu_ff_hilo", {hi, lo}, 64'h00000001_FFFFFFFE);
    run_mul(2'b01, 32'h80000000, 32'h80000000, -1, -1);
    chk("multu_8000_hilo", {hi, lo}, 64'h40000000_00000000);

    // moves
    run_mt(2'b10, 32'h12345678);
    run_mt(2'b11, 32'h9ABCDEF0);
    chk("mt_pair_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);

    // cancel in second RUN cycle
    run_mul(2'b00, 32'd7, 32'd6, 1, -1);
    chk("cancel_hilo_kept", {hi, lo}, 64'h12345678_9ABCDEF0);

    // cancel together with start in IDLE: start ignored
    op = 2'b10; rs_val = 32'hDEADBEEF; start = 1'b1; cancel = 1'b1;
    step();
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start_done", 64'(done), 64'd0);
    chk("cancel_start_busy", 64'(busy), 64'd0);
    chk("cancel_start_hi", 64'(hi), 64'h12345678);

    // new start during RUN is ignored
    run_mul(2'b00, 32'd11, 32'd13, -1, 1);
    chk("inject_hilo", {hi, lo}, 64'd143);

    // random mix
    for (int k = 0; k < 24; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (ro[1]) run_mt(ro, ra);
      else       run_mul(ro, ra, rb, -1, -1);
    end

    // reset in the middle of RUN
    op = 2'b00; rs_val = $urandom; rt_val = $urandom; start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_mul_en", 64'(mul_en), 64'd0);
    chk("mid_rst_hilo", {hi, lo}, 64'd0);
    chk("mid_rst_mul_ab", {mul_a, mul_b}, 64'd0);
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_no_done", 64'(done), 64'd0);
      chk("post_rst_hilo", {hi, lo}, 64'd0);
    end
    run_mul(2'b00, 32'd2, 32'd3, -1, -1);
    chk("post_rst_mult", {hi, lo}, 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
